// File: rtl/mac_pkg.sv
// Shared types, defaults and saturating arithmetic helpers for the
// multiply-accumulate stage.
package mac_pkg;

    // Default geometry of the MAC stage.
    localparam int DEF_N     = 8;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_CNT_W = 8;

    // Widths at which the saturating helpers operate; callers zero-extend
    // their operands into these and take the low bits of the result back.
    localparam int SAT_MAX_W = 64;
    localparam int CNT_MAX_W = 32;

    // Operand beat record at the default operand width.
    typedef struct packed {
        logic [DEF_N-1:0] a;
        logic [DEF_N-1:0] b;
        logic             first;
        logic             last;
    } stage_t;

    // Result of a saturating add: overflow flag above the clipped sum.
    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W-1:0] sum;
    } sat_sum_t;

    // Adds two unsigned values and clips the result to acc_w bits.
    function automatic sat_sum_t sat_add(
        input logic [SAT_MAX_W-1:0] acc,
        input logic [SAT_MAX_W-1:0] p,
        input int unsigned          acc_w
    );
        logic [SAT_MAX_W:0] raw;
        logic [SAT_MAX_W:0] limit;
        sat_sum_t           res;
        raw   = {1'b0, acc} + {1'b0, p};
        limit = ({{SAT_MAX_W{1'b0}}, 1'b1} << acc_w) - {{SAT_MAX_W{1'b0}}, 1'b1};
        if (raw > limit) begin
            res.ovf = 1'b1;
            res.sum = limit[SAT_MAX_W-1:0];
        end else begin
            res.ovf = 1'b0;
            res.sum = raw[SAT_MAX_W-1:0];
        end
        return res;
    endfunction

    // Increments a counter that sticks at all-ones for a cnt_w-bit field.
    function automatic logic [CNT_MAX_W-1:0] sat_inc(
        input logic [CNT_MAX_W-1:0] cnt,
        input int unsigned          cnt_w
    );
        logic [CNT_MAX_W:0]   limit;
        logic [CNT_MAX_W-1:0] res;
        limit = ({{CNT_MAX_W{1'b0}}, 1'b1} << cnt_w) - {{CNT_MAX_W{1'b0}}, 1'b1};
        if ({1'b0, cnt} >= limit) begin
            res = limit[CNT_MAX_W-1:0];
        end else begin
            res = cnt + {{(CNT_MAX_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/multiplier_core.sv
// Unsigned N x N array multiplier: sum of shifted partial products.
module multiplier_core #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    logic [2*N-1:0] a_ext_s;

    assign a_ext_s = {{N{1'b0}}, a_i};

    // Accumulate one partial-product row per multiplier bit.
    always_comb begin
        p_o = {(2*N){1'b0}};
        for (int i = 0; i < N; i++) begin
            if (b_i[i]) begin
                p_o = p_o + (a_ext_s << i);
            end else begin
                p_o = p_o;
            end
        end
    end

endmodule

// File: rtl/mac_accumulate.sv
// Pipelined multiply-accumulate stage: operand register, product register,
// saturating burst accumulator and a held result register on a
// valid/ready output. A single stall signal freezes the whole pipe while
// an emitted result waits for the consumer.
module mac_accumulate
    import mac_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    // Elaboration-time geometry checks.
    if (ACC_W < 2 * N) begin : g_acc_too_narrow
        $error("mac_accumulate: ACC_W must be at least 2*N");
    end
    if (ACC_W >= SAT_MAX_W) begin : g_acc_too_wide
        $error("mac_accumulate: ACC_W must be below SAT_MAX_W");
    end
    if ((CNT_W < 1) || (CNT_W >= CNT_MAX_W)) begin : g_cnt_width
        $error("mac_accumulate: CNT_W out of range");
    end

    // Operand beat at the instantiated operand width.
    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         first;
        logic         last;
    } beat_t;

    logic                 adv_s;

    // Stage 1: registered operands.
    logic                 v1_q, v1_d;
    beat_t                s1_q, s1_d;

    // Stage 2: registered product.
    logic [2*N-1:0]       prod_s;
    logic                 v2_q, v2_d;
    logic [ACC_W-1:0]     p_q, p_d;
    logic                 first2_q, first2_d;
    logic                 last2_q, last2_d;

    // Stage 3: running burst state.
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Held result.
    logic                 out_valid_q, out_valid_d;
    logic [ACC_W-1:0]     out_acc_q, out_acc_d;
    logic                 out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]     out_count_q, out_count_d;

    // Stage 3 arithmetic.
    logic [ACC_W-1:0]           acc_base_s;
    logic                       sat_ovf_s;
    logic [SAT_MAX_W-ACC_W-1:0] sat_pad_s;
    logic [ACC_W-1:0]           sat_sum_s;
    logic                       sat_hit_s;
    logic [ACC_W-1:0]           acc_new_s;
    logic                       ovf_new_s;
    logic [CNT_MAX_W-CNT_W-1:0] cnt_pad_s;
    logic [CNT_W-1:0]           cnt_inc_s;
    logic [CNT_W-1:0]           cnt_new_s;

    // The pipe moves unless a result is held against a stalled consumer.
    assign adv_s    = !(out_valid_q && !out_ready);
    assign in_ready = adv_s;

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

    multiplier_core #(
        .N (N)
    ) u_mul (
        .a_i (s1_q.a),
        .b_i (s1_q.b),
        .p_o (prod_s)
    );

    // Next accumulator value, overflow flag and term count for the stage-2 beat.
    always_comb begin
        acc_base_s = first2_q ? {ACC_W{1'b0}} : acc_q;
        {sat_ovf_s, sat_pad_s, sat_sum_s} =
            sat_add(SAT_MAX_W'(acc_base_s), SAT_MAX_W'(p_q), ACC_W);
        // Any bit above ACC_W means the value did not fit: treat as saturation.
        sat_hit_s  = sat_ovf_s | (|sat_pad_s);
        acc_new_s  = sat_hit_s ? {ACC_W{1'b1}} : sat_sum_s;
        ovf_new_s  = sat_hit_s ? 1'b1 : (first2_q ? 1'b0 : ovf_q);
        {cnt_pad_s, cnt_inc_s} = sat_inc(CNT_MAX_W'(cnt_q), CNT_W);
        if (first2_q) begin
            cnt_new_s = CNT_W'(1'b1);
        end else if (|cnt_pad_s) begin
            cnt_new_s = {CNT_W{1'b1}};
        end else begin
            cnt_new_s = cnt_inc_s;
        end
    end

    // Pipeline advance, accumulation and result emission when not stalled.
    always_comb begin
        v1_d        = v1_q;
        s1_d        = s1_q;
        v2_d        = v2_q;
        p_d         = p_q;
        first2_d    = first2_q;
        last2_d     = last2_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        if (adv_s) begin
            v1_d = in_valid;
            if (in_valid) begin
                s1_d.a     = in_a;
                s1_d.b     = in_b;
                s1_d.first = in_first;
                s1_d.last  = in_last;
            end else begin
                s1_d = s1_q;
            end
            v2_d     = v1_q;
            p_d      = ACC_W'(prod_s);
            first2_d = s1_q.first;
            last2_d  = s1_q.last;
            // Advancing means any held result has been taken this edge.
            out_valid_d = 1'b0;
            if (v2_q) begin
                if (last2_q) begin
                    out_valid_d = 1'b1;
                    out_acc_d   = acc_new_s;
                    out_ovf_d   = ovf_new_s;
                    out_count_d = cnt_new_s;
                    acc_d       = {ACC_W{1'b0}};
                    ovf_d       = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                end else begin
                    acc_d = acc_new_s;
                    ovf_d = ovf_new_s;
                    cnt_d = cnt_new_s;
                end
            end else begin
                acc_d = acc_q;
            end
        end else begin
            v1_d = v1_q;
        end
    end

    // State registers with synchronous reset; in-flight beats are dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            s1_q        <= {$bits(beat_t){1'b0}};
            v2_q        <= 1'b0;
            p_q         <= {ACC_W{1'b0}};
            first2_q    <= 1'b0;
            last2_q     <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            ovf_q       <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_acc_q   <= {ACC_W{1'b0}};
            out_ovf_q   <= 1'b0;
            out_count_q <= {CNT_W{1'b0}};
        end else begin
            v1_q        <= v1_d;
            s1_q        <= s1_d;
            v2_q        <= v2_d;
            p_q         <= p_d;
            first2_q    <= first2_d;
            last2_q     <= last2_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulate.sv
// Directed bench for mac_accumulate (16-bit accumulator so saturation is reachable).
module tb_mac_accumulate;

    localparam int N     = 8;
    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    mac_accumulate #(
        .N     (N),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        f;
        logic        l;
        logic        e_valid;
        logic [15:0] e_acc;
        logic        e_ovf;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] a, input logic [7:0] b,
                                input logic f, input logic l, input logic ev,
                                input logic [15:0] eacc, input logic eovf, input logic [7:0] ecnt);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.f = f; r.l = l;
        r.e_valid = ev; r.e_acc = eacc; r.e_ovf = eovf; r.e_cnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic f, input logic l);
        in_valid = v; in_a = a; in_b = b; in_first = f; in_last = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [15:0] eacc,
                           input logic eovf, input logic [7:0] ecnt);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, "_acc"},   {16'd0, out_acc},   {16'd0, eacc});
        chk({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, eovf});
        chk({tag, "_cnt"},   {24'd0, out_count}, {24'd0, ecnt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        // Row i: inputs sampled at the coming edge; expected outputs are those
        // visible before that edge (a beat in row k is seen in row k+3).
        tbl.push_back(mk(1'b1, 8'd200, 8'd150, 1'b1, 1'b1, 1'b0, 16'd0,     1'b0, 8'd0)); // 0
        tbl.push_back(mk(1'b1, 8'd3,   8'd4,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0, 8'd0)); // 1
        tbl.push_back(mk(1'b1, 8'd5,   8'd6,   1'b0, 1'b0, 1'b0, 16'd0,     1'b0, 8'd0)); // 2
        tbl.push_back(mk(1'b1, 8'd7,   8'd8,   1'b0, 1'b0, 1'b1, 16'd30000, 1'b0, 8'd1)); // 3
        tbl.push_back(mk(1'b1, 8'd9,   8'd10,  1'b0, 1'b1, 1'b0, 16'd30000, 1'b0, 8'd1)); // 4
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd30000, 1'b0, 8'd1)); // 5
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd30000, 1'b0, 8'd1)); // 6
        tbl.push_back(mk(1'b1, 8'd10,  8'd10,  1'b1, 1'b0, 1'b1, 16'd188,   1'b0, 8'd4)); // 7
        tbl.push_back(mk(1'b1, 8'd2,   8'd2,   1'b1, 1'b0, 1'b0, 16'd188,   1'b0, 8'd4)); // 8
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd188,   1'b0, 8'd4)); // 9
        tbl.push_back(mk(1'b1, 8'd3,   8'd3,   1'b0, 1'b1, 1'b0, 16'd188,   1'b0, 8'd4)); // 10
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd188,   1'b0, 8'd4)); // 11
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd188,   1'b0, 8'd4)); // 12
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 16'd13,    1'b0, 8'd2)); // 13
        tbl.push_back(mk(1'b1, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 16'd13,    1'b0, 8'd2)); // 14
        tbl.push_back(mk(1'b1, 8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 16'd13,    1'b0, 8'd2)); // 15
        tbl.push_back(mk(1'b1, 8'd2,   8'd3,   1'b1, 1'b1, 1'b0, 16'd13,    1'b0, 8'd2)); // 16
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd13,    1'b0, 8'd2)); // 17
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 16'hFFFF,  1'b1, 8'd2)); // 18
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 16'd6,     1'b0, 8'd1)); // 19
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd6,     1'b0, 8'd1)); // 20
        tbl.push_back(mk(1'b1, 8'd1,   8'd1,   1'b0, 1'b0, 1'b0, 16'd6,     1'b0, 8'd1)); // 21
        tbl.push_back(mk(1'b1, 8'd2,   8'd2,   1'b0, 1'b1, 1'b0, 16'd6,     1'b0, 8'd1)); // 22
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd6,     1'b0, 8'd1)); // 23
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd6,     1'b0, 8'd1)); // 24
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 16'd5,     1'b0, 8'd2)); // 25
        tbl.push_back(mk(1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 16'd5,     1'b0, 8'd2)); // 26

        // Reset state.
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("reset", 1'b0, 16'd0, 1'b0, 8'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Table: single term, four-term burst, mid-burst first with a gap,
        // saturation then recovery, burst without a leading first.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].l);
            #1;
            chk_out($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_acc, tbl[i].e_ovf, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
        end

        // Backpressure: result (5*5) held while a 3-term burst queues behind it.
        out_ready = 1'b0;
        drive(1'b1, 8'd5, 8'd5, 1'b1, 1'b1); tick();
        drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b0); tick();
        drive(1'b1, 8'd1, 8'd1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            chk_out($sformatf("bp_hold%0d", c), 1'b1, 16'd25, 1'b0, 8'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                pulses++;
                chk_out("bp_drain", 1'b1, 16'd3, 1'b0, 8'd3);
            end
            tick();
        end
        chk("bp_pulses", pulses, 32'd1);

        // Reset with two beats in flight and a result held.
        out_ready = 1'b0;
        drive(1'b1, 8'd6, 8'd6, 1'b1, 1'b1); tick();
        drive(1'b1, 8'd7, 8'd7, 1'b1, 1'b0); tick();
        drive(1'b1, 8'd8, 8'd8, 1'b0, 1'b0); tick();
        chk_out("rst_pre", 1'b1, 16'd36, 1'b0, 8'd1);
        rst = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        chk_out("rst_post", 1'b0, 16'd0, 1'b0, 8'd0);
        chk("rst_post_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'd4, 8'd4, 1'b1, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                pulses++;
                chk_out("rst_after", 1'b1, 16'd16, 1'b0, 8'd1);
            end
            tick();
        end
        chk("rst_after_pulses", pulses, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
